// File: rtl/itof.sv
// Two-stage signed 32-bit integer to IEEE-754 single converter with a shared hold.
// Stage 1 takes |x| and its leading-zero count; stage 2 normalises, rounds and packs.
module itof #(
  parameter bit TIE_EVEN = 1'b0
) (
  input  logic        sys_clk,
  input  logic        rstn,
  input  logic        stage1_valid,
  input  logic [31:0] x,
  input  logic        stall,
  output logic [31:0] y,
  output logic        out_valid
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic [5:0]  lz;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  // Highest set bit wins because the scan runs upward; 32 when v is zero.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = 6'(31 - i);
    return n;
  endfunction

  s1_t               s1_d, s1_q;
  logic [STAGES:1]   vld_pipe;
  logic [31:0]       mag;

  // -x wraps for 0x80000000, which is exactly the magnitude wanted.
  always_comb begin
    mag       = x[31] ? (~x + 32'd1) : x;
    s1_d.sign = x[31];
    s1_d.mag  = mag;
    s1_d.lz   = lzc32(mag);
  end

  logic [31:0] norm;
  logic [7:0]  e_base;
  logic        g, st, rnd;
  logic [30:0] packed_mag;
  f32_t        res;

  // Adding the round bit into {exp, frac} lets a mantissa carry bump the
  // exponent and clear frac in one step.
  always_comb begin
    norm       = s1_q.mag << s1_q.lz;
    e_base     = 8'd158 - {2'b00, s1_q.lz};
    g          = norm[7];
    st         = |norm[6:0];
    if (TIE_EVEN) rnd = g & (st | norm[8]);
    else          rnd = g;
    packed_mag = {e_base, norm[30:8]} + {30'd0, rnd};
    res        = '0;
    if (norm[31]) begin
      res.sign = s1_q.sign;
      res.exp  = packed_mag[30:23];
      res.frac = packed_mag[22:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
      y        <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], stage1_valid};
      y        <= res;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!stall) s1_q <= s1_d;
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_itof.sv
// Bench for itof: both tie rules side by side, a directed vector table, stall and
// reset sequences, then random traffic checked through an in-order scoreboard.
module tb_itof;

  logic        sys_clk = 1'b0;
  logic        rstn, stage1_valid, stall;
  logic [31:0] x;
  logic [31:0] y0, y1;
  logic        ov0, ov1;

  always #5 sys_clk = ~sys_clk;

  itof #(.TIE_EVEN(1'b0)) dut0 (.sys_clk(sys_clk), .rstn(rstn), .stage1_valid(stage1_valid),
                               .x(x), .stall(stall), .y(y0), .out_valid(ov0));
  itof #(.TIE_EVEN(1'b1)) dut1 (.sys_clk(sys_clk), .rstn(rstn), .stage1_valid(stage1_valid),
                               .x(x), .stall(stall), .y(y1), .out_valid(ov1));

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [31:0] exp0_in, exp1_in;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: explicit shift-and-round on the magnitude.
  function automatic logic [31:0] ref_f(input logic [31:0] xi, input bit tie_even);
    logic        s;
    logic [31:0] m;
    logic [63:0] mant, rem, half;
    int          p, sh;
    s = xi[31];
    m = s ? (~xi + 32'd1) : xi;
    if (m == 32'd0) return 32'd0;
    p = 31;
    while (!m[p]) p--;
    if (p <= 23) begin
      mant = {32'd0, m} << (23 - p);
    end else begin
      sh   = p - 23;
      mant = {32'd0, m} >> sh;
      rem  = {32'd0, m} & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (!tie_even || mant[0]))) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        p++;
      end
    end
    return {s, 8'(127 + p), mant[22:0]};
  endfunction

  // Scoreboard: push on accepted inputs, pop when the output register advances.
  always begin
    logic r_s, st_s, v_s;
    logic [31:0] e0, e1;
    @(posedge sys_clk);
    r_s = rstn; st_s = stall; v_s = stage1_valid; e0 = exp0_in; e1 = exp1_in;
    if (!r_s) begin
      q0.delete();
      q1.delete();
    end else if (!st_s) begin
      if (v_s) begin
        q0.push_back(e0);
        q1.push_back(e1);
        n_acc++;
      end
      #1;
      chk("valid_match", {31'd0, ov1}, {31'd0, ov0});
      if (ov0) begin
        n_out++;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got y0=%h with out_valid=1, required no output", y0);
        end else begin
          chk("y_tie_away", y0, q0.pop_front());
          if (q1.size() != 0) chk("y_tie_even", y1, q1.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt[13];

  task automatic drive(input logic [31:0] xv, input logic v, input logic [31:0] e0, input logic [31:0] e1);
    x = xv; stage1_valid = v; exp0_in = e0; exp1_in = e1;
  endtask

  initial begin
    int acc0, out0;
    vt[0]  = '{32'd1,        32'h3F800000, 32'h3F800000};
    vt[1]  = '{32'hFFFFFFFF, 32'hBF800000, 32'hBF800000};
    vt[2]  = '{32'd3,        32'h40400000, 32'h40400000};
    vt[3]  = '{32'd0,        32'h00000000, 32'h00000000};
    vt[4]  = '{32'h80000000, 32'hCF000000, 32'hCF000000};
    vt[5]  = '{32'h7FFFFFFF, 32'h4F000000, 32'h4F000000};
    vt[6]  = '{32'h00FFFFFF, 32'h4B7FFFFF, 32'h4B7FFFFF};
    vt[7]  = '{32'd16777217, 32'h4B800001, 32'h4B800000};
    vt[8]  = '{32'd16777219, 32'h4B800002, 32'h4B800002};
    vt[9]  = '{32'hFEFFFFFF, 32'hCB800001, 32'hCB800000};
    vt[10] = '{32'd16777218, 32'h4B800001, 32'h4B800001};
    vt[11] = '{32'd2,        32'h40000000, 32'h40000000};
    vt[12] = '{32'd33554438, 32'h4C000002, 32'h4C000002};

    rstn = 1'b0; stall = 1'b0;
    drive(32'd0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("reset_y0", y0, 32'd0);
    chk("reset_ov0", {31'd0, ov0}, 32'd0);
    chk("reset_y1", y1, 32'd0);
    chk("reset_ov1", {31'd0, ov1}, 32'd0);
    rstn = 1'b1;

    // Directed table, back to back; output valid only from the third slot on.
    for (int i = 0; i < 13; i++) begin
      chk("latency_ov", {31'd0, ov0}, {31'd0, (i >= 2)});
      drive(vt[i].x, 1'b1, vt[i].e0, vt[i].e1);
      @(negedge sys_clk);
    end
    drive(32'd0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge sys_clk);

    // Stall with 5 at the output and 7 in stage 1.
    drive(32'd5, 1'b1, 32'h40A00000, 32'h40A00000);
    @(negedge sys_clk);
    drive(32'd7, 1'b1, 32'h40E00000, 32'h40E00000);
    @(negedge sys_clk);
    stall = 1'b1;
    drive(32'd99, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
    for (int c = 0; c < 4; c++) begin
      chk("stall_y", y0, 32'h40A00000);
      chk("stall_ov", {31'd0, ov0}, 32'd1);
      if (c < 3) @(negedge sys_clk);
    end
    stall = 1'b0;
    drive(32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge sys_clk);
    chk("post_stall_y", y0, 32'h40E00000);
    chk("post_stall_ov", {31'd0, ov0}, 32'd1);
    @(negedge sys_clk);
    chk("post_stall_drain", {31'd0, ov0}, 32'd0);
    repeat (2) @(negedge sys_clk);

    // Reset while two operands are in flight.
    drive(32'd2, 1'b1, 32'h40000000, 32'h40000000);
    @(negedge sys_clk);
    drive(32'd4, 1'b1, 32'h40800000, 32'h40800000);
    rstn = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b1;
    drive(32'd0, 1'b0, 32'd0, 32'd0);
    chk("midrst_y0", y0, 32'd0);
    chk("midrst_ov0", {31'd0, ov0}, 32'd0);
    chk("midrst_y1", y1, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      chk("midrst_quiet", {31'd0, ov0}, 32'd0);
    end

    // Random traffic with stalls and bubbles.
    acc0 = n_acc; out0 = n_out;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] xv;
      logic v;
      case ($urandom_range(0, 3))
        0: xv = $urandom;
        1: xv = $urandom_range(0, 2000) - 32'd1000;
        2: xv = (32'd1 << $urandom_range(24, 30)) + $urandom_range(0, 300);
        default: xv = ($urandom_range(0, 1) != 0) ? (32'h80000000 + $urandom_range(0, 255))
                                                   : (32'h7FFFFFFF - $urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) != 0) xv = ~xv + 32'd1;
      stall = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(xv, v, ref_f(xv, 1'b0), ref_f(xv, 1'b1));
      @(negedge sys_clk);
    end
    stall = 1'b0;
    drive(32'd0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge sys_clk);
    chk("drain_empty", q0.size(), 32'd0);
    chk("out_count", n_out - out0, n_acc - acc0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
